// File: rtl/unit_literal_select.sv
// ============================================================================
// Module   : unit_literal_select (with package common)
// Purpose  : Scans a captured formula one literal slot per cycle and selects
//            the first unit-clause literal, or else a fallback branch literal.
// Revision : 1.0
// ============================================================================
`default_nettype none

package common;
    localparam int width_clausearray = 2;
    localparam int width_litarray    = 2;
    localparam int width_varnum      = 6;

    typedef struct packed {
        logic [width_varnum-1:0] num;
        logic                    val;
    } lit;

    localparam lit zero_lit = '{num: '0, val: 1'b0};

    typedef struct packed {
        logic [width_litarray:0]          len;
        lit [2**width_litarray-1:0]       lits;
    } clause;

    typedef struct packed {
        logic [width_clausearray:0]       len;
        clause [2**width_clausearray-1:0] clauses;
    } formula;
endpackage

module unit_literal_select
    import common::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   find,
    input  formula in_formula,
    output logic   busy,
    output logic   ended,
    output logic   found_unit,
    output logic   empty_clause,
    output logic   empty_formula,
    output lit     out_lit
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        BEGIN_CLAUSE = 2'd1,
        SCAN_LIT     = 2'd2,
        DONE         = 2'd3
    } state_t;

    state_t                     r_state, w_state;
    formula                     r_fm, w_fm;
    logic [width_clausearray:0] r_i, w_i;
    logic [width_litarray:0]    r_j, w_j;
    logic [1:0]                 r_count, w_count;
    lit                         r_cand, w_cand;
    lit                         r_fb, w_fb;
    logic                       r_have_fb, w_have_fb;
    logic                       w_busy, w_ended, w_found_unit;
    logic                       w_empty_clause, w_empty_formula;
    lit                         w_out_lit;

    clause                      w_cl;
    lit                         w_slot;

    // Indices are only used while in range, so the low bits suffice.
    assign w_cl   = r_fm.clauses[r_i[width_clausearray-1:0]];
    assign w_slot = w_cl.lits[r_j[width_litarray-1:0]];

    always_comb begin
        w_state         = r_state;
        w_fm            = r_fm;
        w_i             = r_i;
        w_j             = r_j;
        w_count         = r_count;
        w_cand          = r_cand;
        w_fb            = r_fb;
        w_have_fb       = r_have_fb;
        w_busy          = busy;
        w_ended         = ended;
        w_found_unit    = found_unit;
        w_empty_clause  = empty_clause;
        w_empty_formula = empty_formula;
        w_out_lit       = out_lit;

        case (r_state)
            IDLE: begin
                if (find) begin
                    w_fm            = in_formula;
                    w_i             = '0;
                    w_have_fb       = 1'b0;
                    w_busy          = 1'b1;
                    w_found_unit    = 1'b0;
                    w_empty_clause  = 1'b0;
                    w_empty_formula = 1'b0;
                    w_out_lit       = zero_lit;
                    w_state         = BEGIN_CLAUSE;
                end
            end
            BEGIN_CLAUSE: begin
                if (r_i >= r_fm.len) begin
                    w_ended = 1'b1;
                    w_busy  = 1'b0;
                    w_state = DONE;
                    if (r_fm.len == '0) begin
                        w_empty_formula = 1'b1;
                        w_out_lit       = zero_lit;
                    end else begin
                        w_out_lit    = r_fb;
                        w_found_unit = 1'b0;
                    end
                end else begin
                    w_j     = '0;
                    w_count = 2'd0;
                    w_cand  = zero_lit;
                    w_state = SCAN_LIT;
                end
            end
            SCAN_LIT: begin
                if (r_j < w_cl.len) begin
                    if (w_slot.num != '0) begin
                        if (r_count == 2'd0) w_cand = w_slot;
                        if (r_count != 2'd2) w_count = r_count + 2'd1;
                    end
                    w_j = r_j + 1'b1;
                end else if (r_count == 2'd0) begin
                    w_ended        = 1'b1;
                    w_busy         = 1'b0;
                    w_empty_clause = 1'b1;
                    w_out_lit      = zero_lit;
                    w_state        = DONE;
                end else if (r_count == 2'd1) begin
                    w_ended      = 1'b1;
                    w_busy       = 1'b0;
                    w_found_unit = 1'b1;
                    w_out_lit    = r_cand;
                    w_state      = DONE;
                end else begin
                    // Earliest multi-literal clause supplies the branch decision.
                    if (!r_have_fb) begin
                        w_fb      = r_cand;
                        w_have_fb = 1'b1;
                    end
                    w_i     = r_i + 1'b1;
                    w_state = BEGIN_CLAUSE;
                end
            end
            DONE: begin
                w_ended = 1'b0;
                w_state = IDLE;
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_fm          <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_count       <= 2'd0;
            r_cand        <= zero_lit;
            r_fb          <= zero_lit;
            r_have_fb     <= 1'b0;
            busy          <= 1'b0;
            ended         <= 1'b0;
            found_unit    <= 1'b0;
            empty_clause  <= 1'b0;
            empty_formula <= 1'b0;
            out_lit       <= zero_lit;
        end else begin
            r_state       <= w_state;
            r_fm          <= w_fm;
            r_i           <= w_i;
            r_j           <= w_j;
            r_count       <= w_count;
            r_cand        <= w_cand;
            r_fb          <= w_fb;
            r_have_fb     <= w_have_fb;
            busy          <= w_busy;
            ended         <= w_ended;
            found_unit    <= w_found_unit;
            empty_clause  <= w_empty_clause;
            empty_formula <= w_empty_formula;
            out_lit       <= w_out_lit;
        end
    end

endmodule

`default_nettype wire
